// File: rtl/rf_port_arbiter.sv
// Round-robin arbiter for the register file's single access port, with a
// clear sequencer that zeroes every register in address order on command.
module rf_port_arbiter #(
   parameter int NUM_REQ  = 3,
   parameter int NUM_REGS = 14,
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ-1:0]         req_we,
   input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [DATA_W-1:0]          rsp_rdata,
   output logic                       rsp_err,
   input  logic                       clr_start,
   output logic                       clr_busy,
   output logic                       rf_write_reg,
   output logic [ADDR_W-1:0]          rf_reg_in,
   output logic [DATA_W-1:0]          rf_write_data,
   input  logic [DATA_W-1:0]          rf_reg_out
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] CLEAR = 1'b1;
   localparam logic [ADDR_W:0]   REG_LIMIT = (ADDR_W+1)'(NUM_REGS);
   localparam logic [ADDR_W-1:0] LAST_REG  = ADDR_W'(NUM_REGS - 1);
   localparam logic [PTR_W-1:0]  LAST_REQ  = PTR_W'(NUM_REQ - 1);

   logic [0:0]         state;
   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   win_idx;
   logic [ADDR_W-1:0]  clr_cnt;
   logic [ADDR_W-1:0]  win_addr;
   logic [DATA_W-1:0]  win_wdata;
   logic [NUM_REQ-1:0] eligible;
   logic               win_vld;
   logic               win_we;
   logic               win_in_range;
   int                 cand;

   // Requesters granted last cycle are masked so a held req is not served twice.
   always_comb begin
      eligible = req & ~gnt;
      win_vld  = 1'b0;
      win_idx  = '0;
      cand     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = int'(rr_ptr) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!win_vld && eligible[cand]) begin
            win_vld = 1'b1;
            win_idx = PTR_W'(cand);
         end
      end
   end

   assign win_addr     = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
   assign win_wdata    = req_wdata[int'(win_idx)*DATA_W +: DATA_W];
   assign win_we       = req_we[win_idx];
   assign win_in_range = ({1'b0, win_addr} < REG_LIMIT);
   assign clr_busy     = (state == CLEAR);

   // RF port mux: the clear sequencer owns the port; clr_start pre-empts arbitration.
   always_comb begin
      rf_write_reg  = 1'b0;
      rf_reg_in     = '0;
      rf_write_data = '0;
      if (!reset) begin
         if (state == CLEAR) begin
            rf_write_reg = 1'b1;
            rf_reg_in    = clr_cnt;
         end else if (!clr_start && win_vld) begin
            rf_write_reg  = win_we & win_in_range;
            rf_reg_in     = win_addr;
            rf_write_data = win_wdata;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         clr_cnt   <= '0;
         gnt       <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         gnt <= '0;
         case (state)
            IDLE: begin
               if (clr_start) begin
                  state   <= CLEAR;
                  clr_cnt <= '0;
               end else if (win_vld) begin
                  gnt       <= NUM_REQ'(1) << win_idx;
                  rsp_rdata <= win_in_range ? rf_reg_out : '0;
                  rsp_err   <= ~win_in_range;
                  rr_ptr    <= (win_idx == LAST_REQ) ? '0 : win_idx + PTR_W'(1);
               end
            end
            CLEAR: begin
               if (clr_cnt == LAST_REG) begin
                  state   <= IDLE;
                  clr_cnt <= '0;
               end else begin
                  clr_cnt <= clr_cnt + ADDR_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/rf_port_arbiter.md
Name: rf_port_arbiter

Overview:
- Shares the register file's single address/write port between NUM_REQ requesters with round-robin arbitration and a registered grant/response handshake.
- Includes a clear sequencer that zeroes all registers in order on command.
- Sits between the core's writeback/operand-fetch and loader/debug agents and the RF; sole driver of rf_write_reg, rf_reg_in and rf_write_data.

Parameters:
- NUM_REQ, 3, number of requesters
- NUM_REGS, 14, number of valid registers (addresses 0..NUM_REGS-1)
- DATA_W, 8, register data width
- ADDR_W, 4, register address width

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req  input  NUM_REQ  per-requester request, held until gnt
- req_we  input  NUM_REQ  1 = write, 0 = read
- req_addr  input  NUM_REQ*ADDR_W  packed register addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  input  NUM_REQ*DATA_W  packed write data
- gnt  output  NUM_REQ  one-hot, one-cycle completion pulse (registered)
- rsp_rdata  output  DATA_W  register value at the grant cycle, valid with gnt
- rsp_err  output  1  address out of range, valid with gnt
- clr_start  input  1  pulse: start clear sequence
- clr_busy  output  1  clear sequence in progress
- rf_write_reg  output  1  RF write enable
- rf_reg_in  output  ADDR_W  RF address
- rf_write_data  output  DATA_W  RF write data
- rf_reg_out  input  DATA_W  RF combinational read data

Behaviour:
- Reset (async, asserted): gnt=0, rsp_rdata=0, rsp_err=0, clr_busy=0, state=IDLE, rr pointer=0, clear counter=0; rf_write_reg=0 while reset is high.
- FSM states: IDLE, CLEAR.
- IDLE -> CLEAR on clr_start. clr_start beats any request in the same cycle; no grant issued that cycle.
- CLEAR: clr_busy=1. Counter 0..NUM_REGS-1, one per cycle, driving rf_write_reg=1, rf_reg_in=counter, rf_write_data=0. The clear takes 14 cycles.
- After the write of address NUM_REGS-1 -> IDLE; clr_busy low the next cycle.
- In CLEAR, req is stalled (no gnt) and clr_start is ignored.
- Arbitration, IDLE only, cycle T:
  - Eligible = req & ~gnt.
  - Winner = first eligible index starting at rr pointer, wrapping modulo NUM_REQ.
  - The winner's addr drives rf_reg_in combinationally in T.
  - rf_write_reg = req_we[w] & (addr < NUM_REGS); rf_write_data = req_wdata[w].
  - With no eligible requester: rf_write_reg=0, rf_reg_in=0, rf_write_data=0.
- Response, cycle T+1 (registered at the T edge):
  - gnt[w]=1 for exactly one cycle.
  - rsp_rdata = rf_reg_out sampled in T. For writes this is the pre-write value.
  - rr pointer = (w+1) mod NUM_REQ.
- Requester rules: keep req/we/addr/wdata stable until gnt. In the gnt cycle the requester is masked, so a held req is not serviced twice. A new request may be presented from the gnt cycle onward and is eligible the cycle after.
- Throughput: one access per cycle overall; per requester, at most every other cycle.
- Out of range address (>= NUM_REGS):
  - Granted normally, with no RF write.
  - rsp_err=1 and rsp_rdata=0 with gnt.
  - rsp_err=0 for all in-range accesses.
- gnt=0 cycles: rsp_rdata and rsp_err hold their last values.
- Reset mid-clear: return to IDLE with counter 0. RF contents are partially cleared; no resume.
- Reset mid-handshake: pending requests are dropped silently and re-arbitrated after reset.

Test Plan:
- Reset, then single write: req[0], we=1, addr=5, wdata=0xA5 -> rf_write_reg=1, rf_reg_in=5 same cycle; gnt=3'b001 next cycle; a later read of addr 5 by req[1] returns rsp_rdata=0xA5.
- Round-robin: req=3'b111 held (re-asserted after each gnt), all reads -> gnt sequence 001, 010, 100, 001 on alternate response cycles per requester; no requester granted twice consecutively.
- Write returns old value: reg 3 = 0x11, then req[2] write 0x22 to 3 -> rsp_rdata=0x11; next read of 3 returns 0x22.
- Out of range: req[1] write addr 14, data 0xFF -> rf_write_reg=0, gnt[1]=1, rsp_err=1, rsp_rdata=0; reg contents unchanged.
- Clear: preload regs 0..13 with nonzero values, pulse clr_start together with req[0] -> clr_busy high for 14 cycles; addresses 0..13 written with 0; no gnt during CLEAR; req[0] granted in the first IDLE cycle after; all reads return 0.
- Reset at clear count 6 -> clr_busy=0 immediately; regs 0..5 = 0 and regs 6..13 keep old values; gnt=0 until a new request.
